// File: rtl/mux_arb_n.sv
// mux_arb_n -- N-to-1 channel multiplexer with a one-word registered output.
//
// Selects one of NUM_IN valid/ready input channels per cycle. The choice comes
// either from an external select (ARB_MODE=0) or from a round-robin arbiter
// (ARB_MODE=1). The selected word and its channel index are captured into an
// output register that the downstream side drains with out_valid/out_ready.
// in_ready is combinational from out_ready, so there is no skid buffer. Full
// throughput of one word per cycle is possible while out_ready stays high.
//
// Ports:
//   clk        sole clock, all state updates on the rising edge
//   reset      synchronous, active-high reset
//   in_data    packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational, at most one bit set)
//   sel        channel select, used only when ARB_MODE=0
//   out_data   registered data of the last accepted word
//   out_chan   registered index of the channel that supplied out_data
//   out_valid  registered output valid
//   out_ready  downstream ready
module mux_arb_n #(
  parameter int WIDTH    = 32,
  parameter int NUM_IN   = 4,
  parameter int ARB_MODE = 0,
  localparam int SEL_W   = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_chan,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_chan_q, out_chan_d;
  logic              out_valid_q, out_valid_d;
  // Index of the most recently granted channel; the search starts just above it.
  logic [SEL_W-1:0]  ptr_q, ptr_d;

  logic              load_en;
  logic              grant_ok;
  logic [SEL_W-1:0]  grant_idx;
  logic [NUM_IN-1:0] xfer;
  int                cand;

  // Grant selection and ready generation.
  // NOTE: every variable written here gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin : grant_logic
    load_en   = !out_valid_q || out_ready;
    grant_ok  = 1'b0;
    grant_idx = '0;
    cand      = 0;
    if (ARB_MODE == 0) begin
      // A select value beyond the last channel names nothing.
      grant_ok  = (int'(sel) < NUM_IN);
      grant_idx = sel;
    end else begin
      // Search ptr+1, ptr+2, ... with wrap; the last candidate is ptr itself,
      // which keeps a lone requester granted every cycle.
      for (int k = 1; k <= NUM_IN; k++) begin
        cand = int'(ptr_q) + k;
        if (cand >= NUM_IN) cand = cand - NUM_IN;
        if (!grant_ok && in_valid[cand]) begin
          grant_ok  = 1'b1;
          grant_idx = SEL_W'(cand);
        end
      end
    end
    in_ready = '0;
    if (grant_ok && load_en && !reset) in_ready[grant_idx] = 1'b1;
  end

  // Output register and pointer next-state.
  always_comb begin : next_state
    xfer        = in_valid & in_ready;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (|xfer) begin
      // A transfer also covers the pop-and-push case: new word replaces old.
      out_valid_d = 1'b1;
      out_chan_d  = grant_idx;
      ptr_d       = grant_idx;
      for (int i = 0; i < NUM_IN; i++) begin
        if (xfer[i]) out_data_d = in_data[i*WIDTH +: WIDTH];
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state flops use non-blocking assignments; reset is sampled on the
  // clock edge and wins over any transfer in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= SEL_W'(NUM_IN - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed bench for mux_arb_n: external-select mode with four and three
// channels, and round-robin mode with four channels.
module tb_mux_arb_n;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  // A: external select, 4 channels
  logic [127:0] a_in_data;
  logic [3:0]   a_in_valid, a_in_ready;
  logic [1:0]   a_sel, a_out_chan;
  logic [31:0]  a_out_data;
  logic         a_out_valid, a_out_ready;

  // B: round-robin, 4 channels
  logic [127:0] b_in_data;
  logic [3:0]   b_in_valid, b_in_ready;
  logic [1:0]   b_sel, b_out_chan;
  logic [31:0]  b_out_data;
  logic         b_out_valid, b_out_ready;

  // C: external select, 3 channels
  logic [95:0]  c_in_data;
  logic [2:0]   c_in_valid, c_in_ready;
  logic [1:0]   c_sel, c_out_chan;
  logic [31:0]  c_out_data;
  logic         c_out_valid, c_out_ready;

  mux_arb_n #(.WIDTH(32), .NUM_IN(4), .ARB_MODE(0)) dut_a (
    .clk(clk), .reset(reset), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .sel(a_sel), .out_data(a_out_data),
    .out_chan(a_out_chan), .out_valid(a_out_valid), .out_ready(a_out_ready));

  mux_arb_n #(.WIDTH(32), .NUM_IN(4), .ARB_MODE(1)) dut_b (
    .clk(clk), .reset(reset), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .sel(b_sel), .out_data(b_out_data),
    .out_chan(b_out_chan), .out_valid(b_out_valid), .out_ready(b_out_ready));

  mux_arb_n #(.WIDTH(32), .NUM_IN(3), .ARB_MODE(0)) dut_c (
    .clk(clk), .reset(reset), .in_data(c_in_data), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .sel(c_sel), .out_data(c_out_data),
    .out_chan(c_out_chan), .out_valid(c_out_valid), .out_ready(c_out_ready));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    a_in_data   = {32'h33333333, 32'hDEADBEEF, 32'h22222222, 32'h11111111};
    b_in_data   = {32'hB0000003, 32'hB0000002, 32'hB0000001, 32'hB0000000};
    c_in_data   = {32'hC0000002, 32'hC0000001, 32'hC0000000};
    a_sel = 2'd0; b_sel = 2'd0; c_sel = 2'd0;
    // Requests during reset must not be accepted.
    a_in_valid = 4'b1111; b_in_valid = 4'b1111; c_in_valid = 3'b000;
    a_out_ready = 1'b1; b_out_ready = 1'b1; c_out_ready = 1'b1;
    #1;
    check("rst_a_in_ready", a_in_ready, 4'b0000);
    check("rst_b_in_ready", b_in_ready, 4'b0000);
    step();
    step();
    check("rst_a_out_valid", a_out_valid, 1'b0);
    check("rst_a_out_data", a_out_data, 32'h0);
    check("rst_a_out_chan", a_out_chan, 2'd0);
    check("rst_b_out_valid", b_out_valid, 1'b0);
    check("rst_c_out_valid", c_out_valid, 1'b0);

    reset = 1'b0;
    a_in_valid = 4'b0000; b_in_valid = 4'b0000;
    step();

    // A: basic select of channel 2
    a_sel = 2'd2; a_in_valid = 4'b0100;
    #1;
    check("a_sel2_in_ready", a_in_ready, 4'b0100);
    step();
    check("a_sel2_valid", a_out_valid, 1'b1);
    check("a_sel2_data", a_out_data, 32'hDEADBEEF);
    check("a_sel2_chan", a_out_chan, 2'd2);

    // A: select an idle channel -> no transfer, pending word drains
    a_sel = 2'd3;
    #1;
    check("a_sel3_in_ready", a_in_ready, 4'b1000);
    step();
    check("a_sel3_drain_valid", a_out_valid, 1'b0);

    // A: load with out_ready low, then hold under backpressure
    a_sel = 2'd1; a_in_valid = 4'b0010; a_out_ready = 1'b0;
    step();
    check("a_load_valid", a_out_valid, 1'b1);
    check("a_load_data", a_out_data, 32'h22222222);
    check("a_bp_in_ready", a_in_ready, 4'b0000);
    a_sel = 2'd0; a_in_valid = 4'b1111;
    step();
    check("a_bp_data", a_out_data, 32'h22222222);
    check("a_bp_chan", a_out_chan, 2'd1);
    check("a_bp_valid", a_out_valid, 1'b1);

    // A: pop and push in the same cycle
    a_out_ready = 1'b1;
    #1;
    check("a_pp_in_ready", a_in_ready, 4'b0001);
    step();
    check("a_pp_valid", a_out_valid, 1'b1);
    check("a_pp_data", a_out_data, 32'h11111111);
    check("a_pp_chan", a_out_chan, 2'd0);
    a_in_valid = 4'b0000;
    step();
    check("a_idle_valid", a_out_valid, 1'b0);

    // C: 3 channels, select 3 names nothing
    c_sel = 2'd3; c_in_valid = 3'b111;
    #1;
    check("c_sel3_in_ready", c_in_ready, 3'b000);
    step();
    check("c_sel3_valid", c_out_valid, 1'b0);
    c_sel = 2'd2;
    #1;
    check("c_sel2_in_ready", c_in_ready, 3'b100);
    step();
    check("c_sel2_chan", c_out_chan, 2'd2);
    check("c_sel2_data", c_out_data, 32'hC0000002);

    // B: all channels requesting -> 0,1,2,3,0,1
    b_in_valid = 4'b1111;
    #1;
    check("b_first_in_ready", b_in_ready, 4'b0001);
    step(); check("b_rr0_chan", b_out_chan, 2'd0); check("b_rr0_valid", b_out_valid, 1'b1);
    step(); check("b_rr1_chan", b_out_chan, 2'd1); check("b_rr1_valid", b_out_valid, 1'b1);
    step(); check("b_rr2_chan", b_out_chan, 2'd2); check("b_rr2_valid", b_out_valid, 1'b1);
    step(); check("b_rr3_chan", b_out_chan, 2'd3); check("b_rr3_valid", b_out_valid, 1'b1);
    step(); check("b_rr4_chan", b_out_chan, 2'd0); check("b_rr4_valid", b_out_valid, 1'b1);
    step(); check("b_rr5_chan", b_out_chan, 2'd1); check("b_rr5_data", b_out_data, 32'hB0000001);

    // B: channels 1 and 3; take 3, stall three cycles, then alternate 1,3,1
    b_in_valid = 4'b1010;
    step();
    check("b_pre_chan", b_out_chan, 2'd3);
    b_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("b_stall_in_ready", b_in_ready, 4'b0000);
      step();
      check("b_stall_data", b_out_data, 32'hB0000003);
      check("b_stall_chan", b_out_chan, 2'd3);
      check("b_stall_valid", b_out_valid, 1'b1);
    end
    b_out_ready = 1'b1;
    #1;
    check("b_release_in_ready", b_in_ready, 4'b0010);
    step(); check("b_alt0_chan", b_out_chan, 2'd1);
    step(); check("b_alt1_chan", b_out_chan, 2'd3);
    step(); check("b_alt2_chan", b_out_chan, 2'd1);

    // B: sole requester granted every cycle
    b_in_valid = 4'b0100;
    step(); check("b_sole0_chan", b_out_chan, 2'd2);
    #1;
    check("b_sole_in_ready", b_in_ready, 4'b0100);
    step(); check("b_sole1_chan", b_out_chan, 2'd2);
    check("b_sole1_valid", b_out_valid, 1'b1);

    // B: reset while a word is held under backpressure
    b_out_ready = 1'b0;
    reset = 1'b1;
    b_in_valid = 4'b1111;
    #1;
    check("b_rst_in_ready", b_in_ready, 4'b0000);
    step();
    check("b_rst_valid", b_out_valid, 1'b0);
    check("b_rst_data", b_out_data, 32'h0);
    check("b_rst_chan", b_out_chan, 2'd0);
    reset = 1'b0;
    b_out_ready = 1'b1;
    #1;
    check("b_post_rst_in_ready", b_in_ready, 4'b0001);
    step();
    check("b_post_rst_chan", b_out_chan, 2'd0);
    check("b_post_rst_data", b_out_data, 32'hB0000000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mux_arb_n.md
MUX_ARB_N -- requirements
Module: mux_arb_n

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, data width per channel in bits (1..64).
REQ-002 SHALL provide parameter NUM_IN, default 4, number of input channels (2..16).
REQ-003 SHALL provide parameter ARB_MODE, default 0, where 0 means external select and 1 means round-robin arbitration.
REQ-004 SHALL derive localparam SEL_W = max(1, clog2(NUM_IN)), not overridable.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port in_data  input  NUM_IN*WIDTH  packed channel data; channel i at bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port in_valid  input  NUM_IN  per-channel valid.
REQ-009 SHALL have port in_ready  output  NUM_IN  per-channel ready, combinational.
REQ-010 SHALL have port sel  input  SEL_W  channel select; used only when ARB_MODE=0, ignored otherwise.
REQ-011 SHALL have port out_data  output  WIDTH  registered selected data.
REQ-012 SHALL have port out_chan  output  SEL_W  registered index of the channel that supplied out_data.
REQ-013 SHALL have port out_valid  output  1  registered output valid.
REQ-014 SHALL have port out_ready  input  1  downstream ready.

Function
REQ-015 SHALL define load_en = !out_valid || out_ready; a transfer on channel i occurs when in_valid[i] && in_ready[i].
REQ-016 SHALL assert at most one in_ready bit per cycle, and only while load_en=1 and reset=0.
REQ-017 ARB_MODE=0: in_ready[i] SHALL equal load_en && (sel==i); sel >= NUM_IN selects nothing, so all in_ready=0 and no transfer.
REQ-018 ARB_MODE=1: grant SHALL go to the first channel with in_valid=1, searching from ptr+1 upward with wrap at NUM_IN-1 -> 0; in_ready[grant]=load_en, all others 0.
REQ-019 ARB_MODE=1: ptr SHALL update to the granted index only on a transfer; ptr SHALL hold when no transfer occurs, including during backpressure.
REQ-020 ARB_MODE=1: a channel that transferred SHALL have lowest priority next cycle; a sole requesting channel SHALL be granted every cycle load_en=1.
REQ-021 On transfer, out_data and out_chan SHALL load the channel's data and index at the next edge, giving a latency of exactly 1 cycle.
REQ-022 out_valid SHALL be set at the edge of any transfer and cleared at an edge where out_ready=1 with no transfer.
REQ-023 On simultaneous output handshake and input transfer, out_valid SHALL remain 1 and new data SHALL replace old, giving a throughput of 1 word per cycle.
REQ-024 While out_valid=1 and out_ready=0, out_data, out_chan, out_valid and ptr SHALL hold stable, and all in_ready SHALL be 0.
REQ-025 in_ready SHALL depend combinationally on out_ready, with no skid buffer; out_* SHALL have no combinational path from inputs.
REQ-026 A change of sel or in_valid while in_ready=0 SHALL have no effect on state.

Reset
REQ-027 With reset=1 at an edge: out_valid=0, out_data=0, out_chan=0, ptr=NUM_IN-1, so channel 0 has first priority.
REQ-028 Reset SHALL override any transfer in the same cycle; in_ready SHALL be all 0 while reset=1.
REQ-029 Reset mid-operation SHALL discard any held output word without it being reported as transferred.

Verification
REQ-030 Mode0, WIDTH=32, NUM_IN=4: sel=2, in_valid=4'b0100, ch2=0xDEADBEEF, out_ready=1 -> next cycle out_valid=1, out_data=0xDEADBEEF, out_chan=2.
REQ-031 Mode0: sel=3 with in_valid[3]=0 -> no transfer, out_valid falls to 0 after the pending word drains; sel=4 when NUM_IN=4 is unreachable for SEL_W=2, so test NUM_IN=3 with sel=3 -> in_ready=0.
REQ-032 Mode1: all four valid continuously, out_ready=1 -> out_chan sequence 0,1,2,3,0,1 with out_valid=1 every cycle.
REQ-033 Mode1: in_valid=4'b1010 and out_ready=0 for 3 cycles with out_valid=1 -> out_data stable, in_ready=0, ptr unchanged; on release, channels alternate 1,3,1.
REQ-034 Pop and push in the same cycle: out_valid stays 1 and out_data changes to the new word with no bubble.
REQ-035 Assert reset while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_data=0, and first grant after reset goes to channel 0.
